tdc_stream_sequencer: RTL and testbench

//  Transmit side of the SiFH histogram input stream. Time-stamps per-pixel photon hit strobes

---
 rtl/sifh_pkg.sv | 30 +++
 rtl/tdc_pixel_slots.sv | 61 ++++++
 rtl/tdc_stream_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_tdc_stream_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifh_pkg.sv
// Shared definitions for the SiFH histogram input stream: default geometry,
// the reserved "no hit" code, the sequencer state type and a width helper.
package sifh_pkg;

  localparam int unsigned NP_DEF       = 10;
  localparam int unsigned PIX_DEF      = 4;
  localparam int unsigned DATA_NUM_DEF = 2;
  localparam int unsigned ACQ_NUM_DEF  = 4;

  // All-ones marks an empty slot; slice to NP bits at the point of use.
  localparam logic [31:0] INVALID_TS = '1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } sifh_state_e;

  // Ceiling log2 with a floor of one bit, so that single-entry counters still
  // get a legal vector width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/tdc_pixel_slots.sv
// Per-pixel timestamp store: DATA_NUM slots filled in arrival order, a fill
// count, a sticky drop flag and a read mux that returns the invalid code for
// slots that were never written in the current acquisition.
module tdc_pixel_slots
  import sifh_pkg::*;
#(
  parameter int unsigned NP       = NP_DEF,
  parameter int unsigned DATA_NUM = DATA_NUM_DEF,
  localparam int unsigned CW      = clog2(DATA_NUM + 1),
  localparam int unsigned IW      = clog2(DATA_NUM)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clear,
  input  logic          wr,
  input  logic [NP-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [NP-1:0] rd_data,
  output logic          overflow
);

  logic [NP-1:0] slot_q [DATA_NUM];
  logic [CW-1:0] cnt_q;
  logic          full;

  assign full = (cnt_q == CW'(DATA_NUM));

  // Fill count and drop flag: a hit with every slot taken is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!res || clear) begin
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else if (wr) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Slot payload needs no reset: the count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_NUM; i++) begin
      if (wr && !full && !clear && (cnt_q == CW'(i))) begin
        slot_q[i] <= wr_data;
      end
    end
  end

  // Read mux: unwritten slots read back as the invalid code.
  always_comb begin
    rd_data = INVALID_TS[NP-1:0];
    for (int i = 0; i < DATA_NUM; i++) begin
      if ((rd_idx == IW'(i)) && (CW'(i) < cnt_q)) begin
        rd_data = slot_q[i];
      end
    end
  end

endmodule

// File: rtl/tdc_stream_sequencer.sv
// Transmit side of the SiFH histogram input stream. An acquisition stamps
// per-pixel hits against an NP-bit timer for 2**NP-1 cycles, then drains
// PIX*DATA_NUM words in pixel-major/slot-minor order. Every ACQ_NUM
// acquisitions a frame completes: frame_done pulses and his_num toggles.
// Optional feature macro STREAM_STALL_EN adds a downstream ready port that
// holds the current drain word until accepted.
module tdc_stream_sequencer
  import sifh_pkg::*;
#(
  parameter int unsigned NP       = NP_DEF,
  parameter int unsigned PIX      = PIX_DEF,
  parameter int unsigned DATA_NUM = DATA_NUM_DEF,
  parameter int unsigned ACQ_NUM  = ACQ_NUM_DEF
) (
  input  logic           clk,
  input  logic           res,
  input  logic           acq_start,
  input  logic [PIX-1:0] hit,
`ifdef STREAM_STALL_EN
  input  logic           ready,
`endif
  output logic [NP-1:0]  data,
  output logic           wr_en,
  output logic           his_num,
  output logic           frame_done,
  output logic           busy,
  output logic           overflow
);

  localparam int unsigned IW = clog2(DATA_NUM);
  localparam int unsigned PW = clog2(PIX + 1);
  localparam int unsigned AW = clog2(ACQ_NUM);
  // Last capture cycle uses timer 2**NP-2; 2**NP-1 is the reserved code.
  localparam logic [NP-1:0] TimerLast = {{(NP-1){1'b1}}, 1'b0};

  sifh_state_e   state_q, state_d;
  logic [NP-1:0] timer_q, timer_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [IW-1:0] slot_q, slot_d;
  logic [AW-1:0] acq_q, acq_d;
  logic          his_q, his_d;
  logic [NP-1:0] data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          fd_q, fd_d;
  logic          busy_q;

  logic           clear;
  logic           capture;
  logic           advance;
  logic [NP-1:0]  word;
  logic [NP-1:0]  pix_rd [PIX];
  logic [PIX-1:0] pix_ovf;

  for (genvar p = 0; p < PIX; p++) begin : g_pix
    tdc_pixel_slots #(
      .NP       (NP),
      .DATA_NUM (DATA_NUM)
    ) u_slots (
      .clk      (clk),
      .res      (res),
      .clear    (clear),
      .wr       (capture && hit[p]),
      .wr_data  (timer_q),
      .rd_idx   (slot_q),
      .rd_data  (pix_rd[p]),
      .overflow (pix_ovf[p])
    );
  end

`ifdef STREAM_STALL_EN
  // A visible word moves on only once the builder has taken it.
  assign advance = !wr_en_q || ready;
`else
  assign advance = 1'b1;
`endif

  // Select the slot-mux output of the pixel currently being drained.
  always_comb begin
    word = INVALID_TS[NP-1:0];
    for (int p = 0; p < PIX; p++) begin
      if (pix_q == PW'(p)) begin
        word = pix_rd[p];
      end
    end
  end

  // Next-state and registered-output logic for IDLE -> CAPTURE -> DRAIN.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pix_d   = pix_q;
    slot_d  = slot_q;
    acq_d   = acq_q;
    his_d   = his_q;
    data_d  = data_q;
    wr_en_d = wr_en_q;
    fd_d    = 1'b0;
    clear   = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_d  = INVALID_TS[NP-1:0];
        wr_en_d = 1'b0;
        if (acq_start) begin
          state_d = CAPTURE;
          timer_d = '0;
          clear   = 1'b1;
        end
      end

      CAPTURE: begin
        capture = 1'b1;
        if (timer_q == TimerLast) begin
          state_d = DRAIN;
          pix_d   = '0;
          slot_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DRAIN: begin
        // Word k is loaded into the output register one cycle after k is
        // selected; pix_q == PIX means the last word is already on the bus.
        if (advance) begin
          if (pix_q == PW'(PIX)) begin
            state_d = IDLE;
            data_d  = INVALID_TS[NP-1:0];
            wr_en_d = 1'b0;
            if (acq_q == AW'(ACQ_NUM - 1)) begin
              acq_d = '0;
              his_d = ~his_q;
              fd_d  = 1'b1;
            end else begin
              acq_d = acq_q + 1'b1;
            end
          end else begin
            data_d  = word;
            wr_en_d = 1'b1;
            if (slot_q == IW'(DATA_NUM - 1)) begin
              slot_d = '0;
              pix_d  = pix_q + 1'b1;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any capture or drain in flight.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      timer_q <= '0;
      pix_q   <= '0;
      slot_q  <= '0;
      acq_q   <= '0;
      his_q   <= 1'b0;
      data_q  <= INVALID_TS[NP-1:0];
      wr_en_q <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pix_q   <= pix_d;
      slot_q  <= slot_d;
      acq_q   <= acq_d;
      his_q   <= his_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      fd_q    <= fd_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign data       = data_q;
  assign wr_en      = wr_en_q;
  assign his_num    = his_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;
  assign overflow   = |pix_ovf;

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Bench for tdc_stream_sequencer at NP=4, PIX=4, DATA_NUM=2, ACQ_NUM=2.
// Acquisition vectors (hit pattern, expected drain words, expected overflow)
// are tabulated and replayed from a run schedule; expected words go into a
// scoreboard queue at acq_start and are popped as the DUT hands them over.
module tb_tdc_stream_sequencer;

  localparam int NP = 4;
  localparam int PIX = 4;
  localparam int DATA_NUM = 2;
  localparam int ACQ_NUM = 2;
`ifdef STREAM_STALL_EN
  localparam int STALL_LEN = 3;
`else
  localparam int STALL_LEN = 0;
`endif

  logic           clk;
  logic           res;
  logic           acq_start;
  logic [PIX-1:0] hit;
  logic           ready;
  logic [NP-1:0]  data;
  logic           wr_en;
  logic           his_num;
  logic           frame_done;
  logic           busy;
  logic           overflow;

  tdc_stream_sequencer #(
    .NP       (NP),
    .PIX      (PIX),
    .DATA_NUM (DATA_NUM),
    .ACQ_NUM  (ACQ_NUM)
  ) dut (
    .clk        (clk),
    .res        (res),
    .acq_start  (acq_start),
    .hit        (hit),
`ifdef STREAM_STALL_EN
    .ready      (ready),
`endif
    .data       (data),
    .wr_en      (wr_en),
    .his_num    (his_num),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0][3:0] hit_at;  // hit vector applied in the cycle with timer = index
    logic [7:0][3:0]  exp;     // expected word k at index k
    logic             ovf;
  } vec_t;

  typedef struct packed {
    logic [1:0] vi;
    logic       poke;
    logic [3:0] stall;
    logic       mid_reset;
  } run_t;

  int nchecks = 0;
  int nfail = 0;
  logic [3:0] exp_q [$];
  int acq_model = 0;
  logic his_model = 1'b0;
  logic ovf_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid cycle must show the queue head; it pops on handover.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {28'h0, data}, 32'hDEAD);
      end else begin
        check("word", {28'h0, data}, {28'h0, exp_q[0]});
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_acq(input vec_t v, input logic poke, input int stall_len);
    int acc;
    int hold;
    int stall_left;
    int cyc;
    int first_cyc;
    int last_cyc;
    logic exp_fd;
    // A hit while idle must not touch slots or the overflow flag.
    hit = '1;
    step;
    hit = '0;
    check("ovf_before_start", {31'h0, overflow}, {31'h0, ovf_prev});
    acq_start = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(v.exp[k]);
    step;
    acq_start = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 32'h0);
    check("busy_capture", {31'h0, busy}, 32'h1);
    for (int t = 0; t < 15; t++) begin
      hit = v.hit_at[t];
      step;
    end
    hit = '0;
    acc = 0;
    hold = 0;
    stall_left = stall_len;
    cyc = 0;
    first_cyc = -1;
    last_cyc = -1;
    while (acc < 8 && cyc < 200) begin
      if (wr_en) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (acc == 2) hold++;
        if (acc == 2 && stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else begin
          ready = 1'b1;
        end
        acq_start = poke && (acc == 1 || acc == 7);
        if (ready) acc++;
      end else begin
        ready = 1'b1;
        acq_start = 1'b0;
      end
      step;
      cyc++;
    end
    ready = 1'b1;
    acq_start = 1'b0;
    acq_model++;
    exp_fd = 1'b0;
    if (acq_model == ACQ_NUM) begin
      acq_model = 0;
      exp_fd = 1'b1;
      his_model = ~his_model;
    end
    check("drain_words", acc, 8);
    check("first_word_latency", first_cyc, 1);
    check("drain_span", last_cyc - first_cyc + 1, 8 + stall_len);
    if (stall_len > 0) check("stall_hold", hold, stall_len + 1);
    check("wr_en_after", {31'h0, wr_en}, 32'h0);
    check("data_after", {28'h0, data}, 32'hF);
    check("busy_after", {31'h0, busy}, 32'h0);
    check("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    check("his_num", {31'h0, his_num}, {31'h0, his_model});
    check("overflow", {31'h0, overflow}, {31'h0, v.ovf});
    check("queue_empty", exp_q.size(), 0);
    step;
    check("frame_done_pulse", {31'h0, frame_done}, 32'h0);
    check("busy_stays_low", {31'h0, busy}, 32'h0);
    ovf_prev = v.ovf;
  endtask

  // Reset while word 3 is on the bus: no further words, all state cleared.
  task automatic run_reset(input vec_t v);
    int seen;
    int cyc;
    acq_start = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(v.exp[k]);
    step;
    acq_start = 1'b0;
    for (int t = 0; t < 15; t++) begin
      hit = v.hit_at[t];
      step;
    end
    hit = '0;
    seen = 0;
    cyc = 0;
    while (seen < 4 && cyc < 50) begin
      if (wr_en) seen++;
      if (seen < 4) begin
        step;
        cyc++;
      end
    end
    check("words_before_reset", seen, 4);
    res = 1'b0;
    step;
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_data", {28'h0, data}, 32'hF);
    check("rst_his_num", {31'h0, his_num}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    res = 1'b1;
    step;
    check("post_rst_wr_en", {31'h0, wr_en}, 32'h0);
    acq_model = 0;
    his_model = 1'b0;
    ovf_prev = 1'b0;
  endtask

  vec_t vecs [4];
  run_t sched [8];

  initial begin
    res = 1'b0;
    acq_start = 1'b0;
    hit = '0;
    ready = 1'b1;

    vecs[0] = '0;
    vecs[0].exp = 32'hFFFF_FFFF;
    vecs[1] = '0;
    vecs[1].hit_at[3] = 4'b0110;
    vecs[1].hit_at[9] = 4'b0010;
    vecs[1].exp = {4'hF, 4'hF, 4'hF, 4'h3, 4'h9, 4'h3, 4'hF, 4'hF};
    vecs[2] = '0;
    vecs[2].hit_at[1] = 4'b0001;
    vecs[2].hit_at[2] = 4'b0001;
    vecs[2].hit_at[5] = 4'b0001;
    vecs[2].exp = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h2, 4'h1};
    vecs[2].ovf = 1'b1;
    vecs[3] = '0;
    vecs[3].hit_at[0] = 4'b1000;
    vecs[3].hit_at[14] = 4'b1111;
    vecs[3].exp = {4'hE, 4'h0, 4'hF, 4'hE, 4'hF, 4'hE, 4'hF, 4'hE};

    sched[0] = '{vi: 2'd0, poke: 1'b0, stall: 4'd0, mid_reset: 1'b0};
    sched[1] = '{vi: 2'd1, poke: 1'b1, stall: 4'd0, mid_reset: 1'b0};
    sched[2] = '{vi: 2'd2, poke: 1'b0, stall: 4'd0, mid_reset: 1'b0};
    sched[3] = '{vi: 2'd1, poke: 1'b0, stall: 4'd0, mid_reset: 1'b1};
    sched[4] = '{vi: 2'd1, poke: 1'b0, stall: 4'd0, mid_reset: 1'b0};
    sched[5] = '{vi: 2'd3, poke: 1'b1, stall: 4'(STALL_LEN), mid_reset: 1'b0};
    sched[6] = '{vi: 2'd0, poke: 1'b0, stall: 4'd0, mid_reset: 1'b0};
    sched[7] = '{vi: 2'd0, poke: 1'b0, stall: 4'd0, mid_reset: 1'b0};

    repeat (3) step;
    check("reset_data", {28'h0, data}, 32'hF);
    check("reset_wr_en", {31'h0, wr_en}, 32'h0);
    check("reset_his_num", {31'h0, his_num}, 32'h0);
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    res = 1'b1;
    step;

    for (int i = 0; i < 8; i++) begin
      if (sched[i].mid_reset) begin
        run_reset(vecs[sched[i].vi]);
      end else begin
        run_acq(vecs[sched[i].vi], sched[i].poke, int'(sched[i].stall));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  // Global watchdog so a wedged run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    nfail++;
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule
